// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared processor encodings and fetch state type
package instruction_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0F000000;
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h9EFFFFFE;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - holdable, flushable IF/ID pipeline register
module if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [31:0]        pc_d,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc,
    output logic               valid
);

    // Flush inserts a bubble but keeps the last PC for debug visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= NOP_WORD;
            pc    <= RESET_PC;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_WORD;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            pc    <= pc_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, fetch FSM and IF/ID capture
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        im_addr,
    input  logic [INSTR_W-1:0] im_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc,
    output logic               id_valid,
    output logic               halted,
    output logic               misalign,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         flush, load, misalign_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_count <= '0;
            misalign    <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load && (fetch_count != {CNT_W{1'b1}}))
                fetch_count <= fetch_count + CNT_W'(1);
            if (misalign_set)
                misalign <= 1'b1;
        end
    end

    // Redirect beats stall in both RUN and HALT; the halting word parks the PC.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        flush        = 1'b0;
        load         = 1'b0;
        misalign_set = 1'b0;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect) begin
                    pc_next      = {redirect_pc[31:2], 2'b00};
                    flush        = 1'b1;
                    misalign_set = |redirect_pc[1:0];
                end else if (!stall) begin
                    load = 1'b1;
                    if (im_data == HALT_WORD)
                        state_next = HALT;
                    else
                        pc_next = pc + 32'd4;
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_next      = {redirect_pc[31:2], 2'b00};
                    flush        = 1'b1;
                    misalign_set = |redirect_pc[1:0];
                    state_next   = RUN;
                end else if (!stall) begin
                    flush = 1'b1;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    assign im_addr = pc;
    assign halted  = (state == HALT);

    if_id_register #(
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (load),
        .instr_d (im_data),
        .pc_d    (pc),
        .instr   (id_instr),
        .pc      (id_pc),
        .valid   (id_valid)
    );

endmodule
